// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register between datapath stages, with an optional
// skid entry, synchronous flush and a saturating backpressure counter.
module pipe_stage_hs #(
  parameter int WIDTH          = 128,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNTW           = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1'b1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] main_r, main_s;
  logic [WIDTH-1:0] skid_r, skid_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [CNTW-1:0]  stall_r, stall_s;
  logic             in_ready_s;

  // With a skid entry in_ready comes from a flop; without one it must look at out_ready.
  assign in_ready_s = (SKID != 0) ? in_ready_r : (!out_valid_r || out_ready);
  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = main_r;
  assign stall_cnt  = stall_r;

  // Next-state and payload steering; flush overrides every handshake.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_s = {WIDTH{1'b0}};
        skid_s = {WIDTH{1'b0}};
      end else begin
        main_s = main_r;
        skid_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_valid) begin
            main_s  = in_data;
            state_s = ST_FULL;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_s  = in_data;
              state_s = ST_FULL;
            end else begin
              state_s = ST_EMPTY;
            end
          end else if (in_valid && (SKID != 0)) begin
            // Younger entry parks in the skid register behind the stalled head.
            skid_s  = in_data;
            state_s = ST_SKIDFULL;
          end else begin
            state_s = ST_FULL;
          end
        end
        ST_SKIDFULL: begin
          if (out_ready) begin
            main_s  = skid_r;
            state_s = ST_FULL;
          end else begin
            state_s = ST_SKIDFULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles the head entry is held by downstream.
  always_comb begin
    stall_s = stall_r;
    if (out_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
      stall_s = stall_r + CNT_ONE;
    end else begin
      stall_s = stall_r;
    end
  end

  // State, payload and flag registers; reset discards every entry at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= ST_EMPTY;
      main_r      <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      stall_r     <= {CNTW{1'b0}};
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      out_valid_r <= (state_s != ST_EMPTY);
      in_ready_r  <= (state_s != ST_SKIDFULL);
      stall_r     <= stall_s;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: skid, saturating-counter and no-skid variants.
module tb_pipe_stage_hs;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_flush = 1'b0;
  logic [15:0] a_in_data = 16'h0000, a_out_data, a_stall;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_flush = 1'b0;
  logic [7:0] b_in_data = 8'h00, b_out_data;
  logic [3:0] b_stall;
  logic c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_flush = 1'b0;
  logic [7:0] c_in_data = 8'h00, c_out_data;
  logic [15:0] c_stall;

  always #5 CLK = ~CLK;

  pipe_stage_hs #(.WIDTH(16), .SKID(1), .CLEAR_ON_FLUSH(1), .CNTW(16)) u_a (
    .CLK(CLK), .nRST(nRST), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .stall_cnt(a_stall));

  pipe_stage_hs #(.WIDTH(8), .SKID(1), .CLEAR_ON_FLUSH(1), .CNTW(4)) u_b (
    .CLK(CLK), .nRST(nRST), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .stall_cnt(b_stall));

  pipe_stage_hs #(.WIDTH(8), .SKID(0), .CLEAR_ON_FLUSH(0), .CNTW(16)) u_c (
    .CLK(CLK), .nRST(nRST), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .flush(c_flush), .stall_cnt(c_stall));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    a_in_valid = 1'b1; a_in_data = 16'hDEAD;
    b_in_valid = 1'b1; b_in_data = 8'hAD;
    c_in_valid = 1'b1; c_in_data = 8'hAD;
    repeat (3) step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got %h want 0000", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d want 0", a_stall); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_noskid got %b want 1", c_in_ready); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_noskid got %b want 0", c_out_valid); end
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    nRST = 1'b1;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 16'(i);
      step();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, a_out_valid); end
      checks++; if (a_out_data !== 16'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, a_out_data, 16'(i)); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 16'h0011;
    step();
    checks++; if (a_out_data !== 16'h0011) begin errors++; $display("FAIL bp_a_data got %h want 0011", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_ready got %b want 1", a_in_ready); end
    a_in_data = 16'h0022;
    step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_skidfull_ready got %b want 0", a_in_ready); end
    checks++; if (a_out_data !== 16'h0011) begin errors++; $display("FAIL bp_head_kept got %h want 0011", a_out_data); end
    a_in_data = 16'h0033;
    step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_refused got %b want 0", a_in_ready); end
    checks++; if (a_out_data !== 16'h0011) begin errors++; $display("FAIL bp_hold_data got %h want 0011", a_out_data); end
    checks++; if (a_stall !== 16'd2) begin errors++; $display("FAIL bp_stall_held got %0d want 2", a_stall); end
    a_out_ready = 1'b1;
    step();
    checks++; if (a_out_data !== 16'h0022) begin errors++; $display("FAIL bp_b_data got %h want 0022", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", a_in_ready); end
    step();
    checks++; if (a_out_data !== 16'h0033) begin errors++; $display("FAIL bp_c_data got %h want 0033", a_out_data); end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_c_valid got %b want 1", a_out_valid); end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", a_out_valid); end
    checks++; if (a_stall !== 16'd2) begin errors++; $display("FAIL bp_stall_final got %0d want 2", a_stall); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 16'h00A1;
    step();
    a_in_data = 16'h00A2;
    step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fl_pre_skidfull got %b want 0", a_in_ready); end
    a_in_data = 16'h00A3; a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_data !== 16'h0000) begin errors++; $display("FAIL fl_main_clear got %h want 0000", a_out_data); end
    checks++; if (u_a.skid_r !== 16'h0000) begin errors++; $display("FAIL fl_skid_clear got %h want 0000", u_a.skid_r); end
    checks++; if (a_stall !== 16'd4) begin errors++; $display("FAIL fl_stall got %0d want 4", a_stall); end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got %b want 0", a_out_valid); end
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h00B1;
    step();
    checks++; if (a_out_data !== 16'h00B1) begin errors++; $display("FAIL fl_next_data got %h want 00b1", a_out_data); end
    a_in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1; b_in_data = 8'h5A;
    step();
    b_in_valid = 1'b0;
    checks++; if (b_stall !== 4'd0) begin errors++; $display("FAIL sat_start got %0d want 0", b_stall); end
    repeat (14) step();
    checks++; if (b_stall !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", b_stall); end
    step();
    checks++; if (b_stall !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", b_stall); end
    repeat (5) step();
    checks++; if (b_stall !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", b_stall); end
    checks++; if (b_out_data !== 8'h5A) begin errors++; $display("FAIL sat_data got %h want 5a", b_out_data); end
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    checks++; if (b_stall !== 4'd15) begin errors++; $display("FAIL sat_after_flush got %0d want 15", b_stall); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush_valid got %b want 0", b_out_valid); end
  endtask

  task automatic test_noskid();
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1; c_in_data = 8'h07;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL ns_empty_ready got %b want 1", c_in_ready); end
    step();
    checks++; if (c_out_data !== 8'h07) begin errors++; $display("FAIL ns_load got %h want 07", c_out_data); end
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL ns_blocked got %b want 0", c_in_ready); end
    c_out_ready = 1'b1; c_in_data = 8'h08;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL ns_comb_ready got %b want 1", c_in_ready); end
    step();
    checks++; if (c_out_data !== 8'h08) begin errors++; $display("FAIL ns_replace got %h want 08", c_out_data); end
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL ns_no_bubble got %b want 1", c_out_valid); end
    c_out_ready = 1'b0; c_in_data = 8'h09;
    step();
    checks++; if (c_out_data !== 8'h08) begin errors++; $display("FAIL ns_refuse got %h want 08", c_out_data); end
    checks++; if (c_stall !== 16'd1) begin errors++; $display("FAIL ns_stall got %0d want 1", c_stall); end
    c_flush = 1'b1;
    step();
    c_flush = 1'b0; c_in_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL ns_flush_valid got %b want 0", c_out_valid); end
    checks++; if (c_out_data !== 8'h08) begin errors++; $display("FAIL ns_flush_hold got %h want 08", c_out_data); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL ns_flush_ready got %b want 1", c_in_ready); end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 16'h00C3;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ar_loaded got %b want 1", a_out_valid); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0000) begin errors++; $display("FAIL ar_data got %h want 0000", a_out_data); end
    checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL ar_stall got %0d want 0", a_stall); end
    step();
    nRST = 1'b1;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_after got %b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_noskid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
